// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck processor and its peripherals:
// UART framing constants, the UART FSM state type and the opcode characters.
package bf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;
  localparam int   UART_DATA_BITS   = 8;
  localparam int   UART_STOP_BITS   = 1;

  localparam logic [7:0] OP_INC        = 8'h2B;  // '+'
  localparam logic [7:0] OP_DEC        = 8'h2D;  // '-'
  localparam logic [7:0] OP_LEFT       = 8'h3C;  // '<'
  localparam logic [7:0] OP_RIGHT      = 8'h3E;  // '>'
  localparam logic [7:0] OP_LOOP_BEGIN = 8'h5B;  // '['
  localparam logic [7:0] OP_LOOP_END   = 8'h5D;  // ']'
  localparam logic [7:0] OP_OUTPUT     = 8'h2E;  // '.'
  localparam logic [7:0] OP_INPUT      = 8'h2C;  // ','

endpackage

// File: rtl/bf_sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty flags and an occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module bf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (level_r == LW'(DEPTH));
  assign empty_s   = (level_r == LW'(0));
  assign do_pop_s  = pop && !empty_s;
  assign do_push_s = push && (!full_s || do_pop_s);

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_s;
  assign empty    = empty_s;
  assign level    = level_r;

endmodule

// File: rtl/bf_stdout_uart.sv
// Processor stdout sink: edge-detects the output strobe, buffers bytes in a
// FIFO and serialises them on an 8N1 UART line with back-to-back frames.
module bf_stdout_uart
  import bf_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    stdout,
  input  logic                          stdout_en,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_t       state_r;
  uart_state_t       state_s;
  logic [BAUD_W-1:0] baud_r;
  logic [BAUD_W-1:0] baud_s;
  logic [2:0]        bit_r;
  logic [2:0]        bit_s;
  logic [7:0]        shift_r;
  logic [7:0]        shift_s;
  logic              tx_r;
  logic              tx_s;
  logic              en_q_r;
  logic              overflow_r;
  logic              push_req_s;
  logic              pop_s;
  logic              baud_last_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [7:0]        head_s;
  logic [LVL_W-1:0]  level_s;

  // Only the rising edge of the strobe pushes, however long it is held.
  assign push_req_s  = stdout_en && !en_q_r;
  assign baud_last_s = (baud_r == BAUD_LAST);

  bf_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push_req_s),
    .push_data (stdout),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (level_s)
  );

  // Next-state, baud/bit counting and shifting for the transmitter.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        baud_s = BAUD_W'(0);
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_s = head_s;
          bit_s   = 3'd0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_last_s) begin
          baud_s  = BAUD_W'(0);
          state_s = DATA;
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last_s) begin
          baud_s  = BAUD_W'(0);
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == BIT_LAST) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more bytes wait.
        if (baud_last_s) begin
          baud_s = BAUD_W'(0);
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_s = head_s;
            bit_s   = 3'd0;
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = BAUD_W'(0);
      end
    endcase

    case (state_s)
      START:   tx_s = UART_START_LEVEL;
      DATA:    tx_s = shift_s[0];
      STOP:    tx_s = UART_STOP_LEVEL;
      default: tx_s = UART_IDLE_LEVEL;
    endcase
  end

  // Transmitter state and registered line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      baud_r  <= BAUD_W'(0);
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= UART_IDLE_LEVEL;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
    end
  end

  // Strobe history and sticky drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      en_q_r <= stdout_en;
      if (push_req_s && fifo_full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign tx        = tx_r;
  assign busy      = (state_r != IDLE) || (level_s != LVL_W'(0));
  assign fifo_full = fifo_full_s;
  assign overflow  = overflow_r;
  assign level     = level_s;

endmodule

// File: tb/tb_bf_stdout_uart.sv
// Randomised scoreboard bench for bf_stdout_uart with a timing-level model of
// push acceptance, pop times and frame contents.
module tb_bf_stdout_uart;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int H     = D / 2;

  logic       clk;
  logic       reset;
  logic [7:0] stdout;
  logic       stdout_en;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;
  logic [2:0] level;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int last_pop = -100000;
  int peak_level = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t     exp_q[$];
  int         acc_push[$];
  int         acc_pop[$];
  logic [7:0] acc_data[$];
  int         drop_c[$];

  bf_stdout_uart #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .stdout    (stdout),
    .stdout_en (stdout_en),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  // ---- reference model: byte j accepted in cycle c_j is popped at
  // p_j = max(c_j+1, p_{j-1}+10D); its frame occupies cycles p_j+1 .. p_j+10D.
  function automatic int model_level(int t);
    int n = 0;
    foreach (acc_push[i]) if (acc_push[i] + 1 <= t && t <= acc_pop[i]) n++;
    return n;
  endfunction

  function automatic int model_frame(int t);
    foreach (acc_pop[i]) if (acc_pop[i] + 1 <= t && t <= acc_pop[i] + 10 * D) return i;
    return -1;
  endfunction

  function automatic int model_tx(int t);
    int i = model_frame(t);
    int k;
    logic [7:0] b;
    if (i < 0) return 1;
    k = (t - acc_pop[i] - 1) / D;
    b = acc_data[i];
    if (k == 0) return 0;
    if (k <= 8) return int'(b[k-1]);
    return 1;
  endfunction

  function automatic int model_busy(int t);
    return (model_level(t) > 0 || model_frame(t) >= 0) ? 1 : 0;
  endfunction

  function automatic int model_ovf(int t);
    foreach (drop_c[i]) if (drop_c[i] < t) return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    acc_push.delete();
    acc_pop.delete();
    acc_data.delete();
    drop_c.delete();
    exp_q.delete();
    last_pop = -100000;
  endfunction

  function automatic void model_push(logic [7:0] b, int c);
    int occ = model_level(c);
    bit popnow = 1'b0;
    int p;
    frame_t f;
    foreach (acc_pop[i]) if (acc_pop[i] == c) popnow = 1'b1;
    if (occ < DEPTH || popnow) begin
      p = (c + 1 > last_pop + 10 * D) ? c + 1 : last_pop + 10 * D;
      acc_push.push_back(c);
      acc_pop.push_back(p);
      acc_data.push_back(b);
      f.data  = b;
      f.start = p + 1;
      exp_q.push_back(f);
      last_pop = p;
    end else begin
      drop_c.push_back(c);
    end
  endfunction

  // ---- per-cycle output checker against the model
  initial begin
    forever begin
      @(negedge clk);
      check("tx", int'(tx), model_tx(cyc));
      check("level", int'(level), model_level(cyc));
      check("busy", int'(busy), model_busy(cyc));
      check("fifo_full", int'(fifo_full), (model_level(cyc) == DEPTH) ? 1 : 0);
      check("overflow", int'(overflow), model_ovf(cyc));
      if (int'(level) > peak_level) peak_level = int'(level);
    end
  end

  // ---- frame monitor: decodes tx mid-bit and pops the scoreboard
  initial begin
    int         st = 0;
    int         n;
    bit         act = 1'b0;
    bit         start_ok = 1'b0;
    logic [7:0] sh = 8'h00;
    frame_t     f;
    forever begin
      @(negedge clk);
      if (!reset) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          st  = cyc;
        end
      end else begin
        n = cyc - st;
        if (n == H) begin
          start_ok = (tx === 1'b0);
        end else if (n > H && (n - H) % D == 0 && (n - H) / D <= 8) begin
          sh[(n - H) / D - 1] = tx;
        end else if (n == H + 9 * D) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame at cycle %0d: got byte %02h, expected none", cyc, sh);
          end else begin
            f = exp_q.pop_front();
            check("frame_data", int'(sh), int'(f.data));
            check("frame_start", st, f.start);
            check("start_bit", int'(start_ok), 1);
            check("stop_bit", int'(tx), 1);
          end
          act = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int hi, input int lo);
    stdout    = b;
    stdout_en = 1'b1;
    model_push(b, cyc);
    repeat (hi) tick();
    stdout_en = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic drain();
    int g = 0;
    while (cyc <= last_pop + 10 * D + 2 && g < 3000) begin
      tick();
      g++;
    end
    check("drain_timeout", (g >= 3000) ? 1 : 0, 0);
  endtask

  initial begin
    logic [7:0] b;
    int hi;
    int lo;
    stdout    = 8'h00;
    stdout_en = 1'b0;
    reset     = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(level), 0);
    check("rst_overflow", int'(overflow), 0);
    repeat (100) tick();

    send(8'h48, 2, 1);
    drain();
    check("single_busy_low", int'(busy), 0);

    peak_level = 0;
    send(8'h41, 20, 2);
    drain();
    check("held_peak_level", peak_level, 1);

    send(8'h48, 2, 2);
    send(8'h69, 2, 2);
    send(8'h0A, 2, 2);
    drain();

    for (int i = 0; i < 60; i++) begin
      b  = 8'($urandom);
      hi = $urandom_range(1, 3);
      lo = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 80) : $urandom_range(1, 4);
      if (hi + lo < 3) lo = 3 - hi;
      send(b, hi, lo);
    end
    drain();

    reset = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      b = 8'h30 + 8'(i);
      send(b, 2, 1);
    end
    drain();
    check("overflow_set", int'(overflow), 1);
    repeat (20) tick();
    check("overflow_sticky", int'(overflow), 1);

    send(8'h55, 2, 1);
    repeat (12) tick();
    reset = 1'b0;
    #1;
    check("midreset_tx", int'(tx), 1);
    check("midreset_level", int'(level), 0);
    model_reset();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("overflow_cleared", int'(overflow), 0);
    send(8'h0F, 2, 1);
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bf_stdout_uart.md
# bf_stdout_uart

Output sink for the brainfuck processor's `stdout`/`stdout_en` port pair. Detects each new output byte, buffers it in a small FIFO, and serialises it on a single 8N1 UART transmit line, so a running program can print without stalling the core. It sits between the processor's `stdout` outputs and the board-level TX pin.

## Interface
Parameters:
- `CLK_DIV`, 16: clock cycles per UART bit; must be at least 2.
- `FIFO_DEPTH`, 16: byte buffer depth; must be a power of two and at least 2.

Ports:
- `clk`  in  1  system clock, same clock as the processor.
- `reset`  in  1  asynchronous, active-low reset.
- `stdout`  in  8  byte from the processor; stable while `stdout_en` is high.
- `stdout_en`  in  1  processor output strobe; one new byte per rising edge.
- `tx`  out  1  UART line, idle high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `overflow`  out  1  sticky; set when a byte is dropped.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Strobe detection:** `stdout_en` may be held high for more than one cycle; the processor holds it for 2. A registered copy `en_q` is kept. A push request is raised in a cycle where `stdout_en=1` and `en_q=0`; `stdout` is captured in that same cycle. A level-high strobe never pushes twice.
- **Push acceptance:** a push is accepted if the FIFO is not full, or if a pop happens in the same cycle. Otherwise the byte is discarded and `overflow` is set to 1. `overflow` is cleared only by reset.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter and go to START.
  - START: `tx=0` for `CLK_DIV` cycles, then go to DATA.
  - DATA: `tx` is the shift-register LSB. Each bit lasts `CLK_DIV` cycles, then the register shifts right. After 8 bits, go to STOP.
  - STOP: `tx=1` for `CLK_DIV` cycles. At the end of STOP, if the FIFO is non-empty, pop and go straight to START with no idle gap. Otherwise go to IDLE.
- **Counters:**
  - Baud counter is $clog2(CLK_DIV) bits wide; it counts 0..CLK_DIV-1 and wraps.
  - Bit counter is 3 bits wide.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - `level` has one extra bit so it can distinguish full from empty.
- **Byte handling:** bytes are sent unaltered, LSB first. A `0x00` byte is sent like any other byte.
- **`busy`** is defined as (state != IDLE) OR (`level` != 0).

## Timing
- **Reset values:** `tx=1`, `busy=0`, `fifo_full=0`, `overflow=0`, `level=0`, FSM=IDLE, `en_q=0`, FIFO empty.
- **Reset mid-frame:** `tx` returns high asynchronously and the frame is truncated. Buffered bytes are lost.
- **Latency:** strobe rising edge sampled in cycle 0 → `level` increments in cycle 1 → pop at the end of cycle 1 → `tx` goes low from cycle 2.
- **Frame length:** exactly 10×`CLK_DIV` cycles. Back-to-back frames are contiguous.
- **Outputs:** all outputs are registered or decoded from registers; no combinational path from inputs to outputs.
- **Processor throughput:** the processor cannot produce bytes faster than one per 3 cycles. The FIFO absorbs bursts; the sustained rate is limited by the UART.

## Structure
- Shared package `bf_pkg` holds:
  - the FSM state enum `uart_state_t` (IDLE, START, DATA, STOP);
  - UART framing constants: idle level 1, start level 0, 8 data bits, 1 stop bit;
  - the existing opcode character constants, so that the processor and its peripherals share one definition.
- One sub-module: `bf_sync_fifo`. It is a parameterised single-clock FIFO with push/pop/full/empty/level, is reusable later for the `,` input path, and is instantiated once here.
- The UART shifter and FSM live in the top module.

## Test plan
- **Reset idle:** hold reset low 5 cycles, release → `tx=1`, `busy=0`, `level=0`, `overflow=0`, stable for 100 cycles.
- **Single byte:** `CLK_DIV=4`; pulse `stdout_en` for 2 cycles with `stdout=0x48` → `tx` low from cycle 2. Bits sampled mid-bit read 0,0,0,1,0,0,1,0, then stop=1. The frame totals 40 cycles and `busy` drops afterwards.
- **Held strobe:** hold `stdout_en` high for 20 cycles with `stdout=0x41` → exactly one frame, and `level` peaks at 1.
- **Burst:** send "Hi\n" (0x48, 0x69, 0x0A) on the processor cadence, with each strobe high 2 cycles and one strobe every 4 cycles → three contiguous frames, 120 cycles total at `CLK_DIV=4`, with no idle gap between frames.
- **Overflow:** `FIFO_DEPTH=4`, `CLK_DIV=16`; push 6 distinct bytes 0x30–0x35 rapidly → `overflow=1`. The transmitted bytes are 0x30–0x34 (the first byte is popped early, which frees a slot). `overflow` stays 1 until reset.
- **Mid-frame reset:** assert reset during the DATA bits of 0x55 → `tx=1` immediately, `level=0`. After release, a new byte 0x0F is sent correctly.
